// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding and default geometry.
package multicycle_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple adder for one chunk; also exposes the carry into its MSB.
module chunk_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[WIDTH];
    cmsb = c[WIDTH-1];
  end

endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract that processes CHUNK bits per clock, LSB chunk first.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [CHUNK-1:0] csum;
  logic             cout;
  logic             cmsb;
  logic [WIDTH-1:0] sum_next;

  // Latched operands shift right each cycle so the active chunk is always the low CHUNK bits.
  chunk_adder #(
    .WIDTH(CHUNK)
  ) u_chunk (
    .a   (a_q[CHUNK-1:0]),
    .b   (b_q[CHUNK-1:0]),
    .cin (carry_q),
    .sum (csum),
    .cout(cout),
    .cmsb(cmsb)
  );

  // Result fills from the top; after N cycles chunk k sits at bits [k*CHUNK +: CHUNK].
  assign sum_next = (sum >> CHUNK) | (WIDTH'(csum) << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub}};
            carry_q  <= sub;
            idx_q    <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= cout;
          sum     <= sum_next;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_q    <= '0;
            carryout <= cout;
            overflow <= cmsb ^ cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: 32/4 instance plus a single-chunk 4/4 instance.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, sub;
  logic [31:0] a, b, sum;
  logic        busy, done, carryout, overflow;

  logic        start4, sub4;
  logic [3:0]  a4, b4, sum4;
  logic        busy4, done4, co4, ov4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_adder #(
    .WIDTH(32),
    .CHUNK(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .carryout(carryout),
    .overflow(overflow)
  );

  multicycle_adder #(
    .WIDTH(4),
    .CHUNK(4)
  ) dut4 (
    .clk     (clk),
    .reset   (reset),
    .start   (start4),
    .sub     (sub4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .sum     (sum4),
    .carryout(co4),
    .overflow(ov4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns edges from the accepting edge to the done cycle.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        output int lat, output logic first_busy);
    start = 1'b1;
    a     = ia;
    b     = ib;
    sub   = isub;
    @(negedge clk);
    start      = 1'b0;
    first_busy = busy;
    lat        = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          pulses;
    logic        fb;
    logic [31:0] res;

    reset  = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    start4 = 1'b0;
    sub4   = 1'b0;
    a4     = '0;
    b4     = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", 32'(carryout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    reset = 1'b0;

    // Start is presented immediately, so it is sampled at the first edge after release.
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, fb);
    check("ovf_lat", 32'(lat), 32'd8);
    check("ovf_busy0", 32'(fb), 32'd1);
    check("ovf_sum", sum, 32'h8000_0000);
    check("ovf_cout", 32'(carryout), 32'd0);
    check("ovf_ovf", 32'(overflow), 32'd1);
    check("ovf_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("sum_held", sum, 32'h8000_0000);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, fb);
    check("wrap_lat", 32'(lat), 32'd8);
    check("wrap_sum", sum, 32'h0000_0000);
    check("wrap_cout", 32'(carryout), 32'd1);
    check("wrap_ovf", 32'(overflow), 32'd0);
    @(negedge clk);

    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, lat, fb);
    check("sub_lat", 32'(lat), 32'd8);
    check("sub_sum", sum, 32'hFFFF_FFFE);
    check("sub_cout", 32'(carryout), 32'd0);
    check("sub_ovf", 32'(overflow), 32'd0);

    // Back-to-back: start presented during the done cycle.
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat, fb);
    check("b2b_lat", 32'(lat), 32'd8);
    check("b2b_busy", 32'(fb), 32'd1);
    check("b2b_sum", sum, 32'h7FFF_FFFF);
    check("b2b_cout", 32'(carryout), 32'd1);
    check("b2b_ovf", 32'(overflow), 32'd1);
    @(negedge clk);

    // Start plus new operands mid-run must be ignored.
    start = 1'b1;
    a     = 32'h0000_0010;
    b     = 32'h0000_0020;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 32'h0000_FFFF;
    b     = 32'h0000_0001;
    sub   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    a      = 32'hAAAA_AAAA;
    b      = 32'h5555_5555;
    pulses = 0;
    res    = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        res = sum;
      end
      @(negedge clk);
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_sum", res, 32'h0000_0030);

    // Reset while index 3 is active.
    start = 1'b1;
    a     = 32'h1111_1111;
    b     = 32'h2222_2222;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", sum, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    // Single-chunk instance: done one edge after acceptance.
    start4 = 1'b1;
    a4     = 4'b1100;
    b4     = 4'b0100;
    sub4   = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    lat    = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("n1_lat", 32'(lat), 32'd1);
    check("n1_sum", 32'(sum4), 32'd0);
    check("n1_cout", 32'(co4), 32'd1);
    check("n1_ovf", 32'(ov4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK (N = WIDTH/CHUNK, N >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only when the block is idle or done.
REQ-006 SHALL have port sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; sampled with start.
REQ-008 SHALL have port busy  output  1  high while chunks are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port sum  output  WIDTH  result, held until the next accepted start.
REQ-011 SHALL have ports carryout, overflow  output  1 each  raw carry out of the MSB, signed two's-complement overflow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-013 IDLE or DONE with start=1 at an edge SHALL latch a, b^{WIDTH{sub}}, carry=sub, chunk index=0, clear sum, and enter RUN.
REQ-014 Each RUN edge SHALL add chunk[index] of the latched operands plus carry, write that CHUNK of sum, update carry, and increment index.
REQ-015 At the RUN edge processing index N-1, the FSM SHALL enter DONE; DONE lasts exactly one cycle, then IDLE unless start is accepted.
REQ-016 Latency: start sampled at edge t -> done high for the cycle following edge t+N; busy high for cycles following edges t..t+N-1.
REQ-017 start while in RUN SHALL be ignored; a, b, sub changes during RUN SHALL not affect the result.
REQ-018 Back-to-back: start=1 in DONE SHALL be accepted; done deasserts and busy asserts the next cycle.
REQ-019 carryout SHALL equal the carry out of bit WIDTH-1 (for sub, 1 = no borrow).
REQ-020 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 sum, carryout, overflow SHALL be stable from the done cycle until the next accepted start.
REQ-022 Sum width SHALL wrap modulo 2^WIDTH; no extra result bits.

Reset
REQ-023 reset SHALL immediately force state IDLE, busy=0, done=0, sum=0, carryout=0, overflow=0, index=0, carry=0.
REQ-024 reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-025 First start SHALL be honoured at the first rising edge after reset deasserts.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding and the default WIDTH/CHUNK constants.
REQ-027 The per-cycle adder SHALL be a sub-module chunk_adder (CHUNK-bit ripple adder: a, b, cin -> sum, cout, carry into MSB).
REQ-028 The index counter SHALL be clog2(N) bits wide, minimum 1.

Verification
REQ-029 WIDTH=32: a=0x7FFFFFFF, b=0x00000001, sub=0 -> done 8 cycles after start; sum=0x80000000, carryout=0, overflow=1.
REQ-030 WIDTH=32: a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, carryout=1, overflow=0.
REQ-031 WIDTH=32: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, carryout=0, overflow=0; then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, carryout=1, overflow=1.
REQ-032 start pulsed during RUN with different operands -> ignored; first result unchanged, single done pulse.
REQ-033 reset asserted at RUN index 3 -> busy=0, sum=0 immediately; no done pulse after release.
REQ-034 WIDTH=4, CHUNK=4 (N=1): a=0b1100, b=0b0100 -> done on cycle after edge t+1; sum=0b0000, carryout=1, overflow=0.
